ifetch_queue: RTL and testbench

- Instruction-fetch stage directly upstream of the instruction control / decode stage.
- Issues word reads to instruction memory over a req/ack handshake and buffers returned opcodes in a small FIFO.
- Presents one opcode per cycle on `op`, with its fetch address on `op_pc`, to the downstream stage.
- On a redirect (branch taken, link recover, or NOP-insert flush) it discards buffered and in-flight fetches and restarts at the new PC.

---
 rtl/ifetch_queue.sv | 134 +++++++++++++
 tb/tb_ifetch_queue.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// Instruction fetch: registered req/ack reads into a DEPTH-entry opcode FIFO; one opcode/cycle at zero wait.
// Requests are issued only when a FIFO slot is guaranteed; redirect flushes the FIFO and drops any stale in-flight read.
module ifetch_queue #(
  parameter int                 DATA_W = 16,
  parameter int                 DEPTH  = 2,
  parameter logic [DATA_W-1:0]  NOP_OP = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              redir_en,
  input  logic [DATA_W-1:0] redir_pc,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] op,
  output logic [DATA_W-1:0] op_pc,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] fetch_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t              state, state_nxt;
  logic                req_nxt;
  logic [DATA_W-1:0]   addr_nxt;
  logic [DATA_W-1:0]   fpc, fpc_nxt;
  logic [CNT_W-1:0]    count, count_nxt;
  logic [PTR_W-1:0]    rd_ptr, wr_ptr;
  logic [DATA_W-1:0]   fifo_op [DEPTH];
  logic [DATA_W-1:0]   fifo_pc [DEPTH];
  logic                ack, push, pop;

  assign ack      = imem_ack & imem_req;
  assign op_valid = (count != '0);
  assign pop      = op_valid & op_ready & ~redir_en;
  assign push     = ack & (state == REQ) & ~redir_en;
  assign op       = op_valid ? fifo_op[rd_ptr] : NOP_OP;
  assign op_pc    = op_valid ? fifo_pc[rd_ptr] : '0;
  assign fetch_pc = fpc;

  always_comb begin
    count_nxt = count + CNT_W'(push) - CNT_W'(pop);
    if (redir_en) count_nxt = '0;
  end

  always_comb begin
    state_nxt = state;
    req_nxt   = imem_req;
    addr_nxt  = imem_addr;
    fpc_nxt   = fpc;
    if (redir_en) begin
      fpc_nxt = redir_pc;
      if (ack || state == IDLE) begin
        state_nxt = REQ;
        req_nxt   = 1'b1;
        addr_nxt  = redir_pc;
      end else begin
        // stale read still in flight: hold it on the bus until the memory acks
        state_nxt = DROP;
      end
    end else begin
      case (state)
        IDLE: begin
          if (count < DEPTH_C) begin
            state_nxt = REQ;
            req_nxt   = 1'b1;
            addr_nxt  = fpc;
          end
        end
        REQ: begin
          if (ack) begin
            fpc_nxt = imem_addr + 1'b1;
            if (count_nxt < DEPTH_C) begin
              addr_nxt = imem_addr + 1'b1;
            end else begin
              state_nxt = IDLE;
              req_nxt   = 1'b0;
            end
          end
        end
        DROP: begin
          if (ack) begin
            state_nxt = REQ;
            addr_nxt  = fpc;
          end
        end
        default: begin
          state_nxt = IDLE;
          req_nxt   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      fpc       <= '0;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
    end else begin
      state     <= state_nxt;
      imem_req  <= req_nxt;
      imem_addr <= addr_nxt;
      fpc       <= fpc_nxt;
      count     <= count_nxt;
      if (redir_en) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Payload storage needs no reset: it is masked by count when empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr] <= imem_addr;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: memory returns addr^16'hA500 so every opcode identifies its own address.
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        redir_en;
  logic [15:0] redir_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] op;
  logic [15:0] op_pc;
  logic        op_valid;
  logic        op_ready;
  logic [15:0] fetch_pc;

  int checks = 0;
  int errors = 0;

  ifetch_queue dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .redir_en   (redir_en),
    .redir_pc   (redir_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .op         (op),
    .op_pc      (op_pc),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .fetch_pc   (fetch_pc)
  );

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ 16'hA500;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in IDLE, empty, one cycle before its first issue edge.
  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n  = 1'b0;
    redir_en = 1'b0;
    redir_pc = 16'h0000;
    imem_ack = 1'b1;
    op_ready = 1'b1;
    #1;
    check("rst_req",   16'(imem_req), 16'd0);
    check("rst_addr",  imem_addr,     16'h0000);
    check("rst_op",    op,            16'h0000);
    check("rst_op_pc", op_pc,         16'h0000);
    check("rst_valid", 16'(op_valid), 16'd0);
    check("rst_fpc",   fetch_pc,      16'h0000);
    tick();
    reset_n = 1'b1;

    // 1: zero-wait streaming
    tick();
    check("t1_req0",   16'(imem_req), 16'd1);
    check("t1_addr0",  imem_addr,     16'h0000);
    check("t1_valid0", 16'(op_valid), 16'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("t1_addr",  imem_addr,     16'(k + 1));
      check("t1_valid", 16'(op_valid), 16'd1);
      check("t1_op",    op,            16'(k) ^ 16'hA500);
      check("t1_op_pc", op_pc,         16'(k));
      check("t1_fpc",   fetch_pc,      16'(k + 1));
    end

    // 2: downstream stalled, fill exactly DEPTH then one pop refills one slot
    op_ready = 1'b0;
    do_reset();
    tick();
    check("t2_addr0", imem_addr, 16'h0000);
    tick();
    check("t2_op0",   op,            16'hA500);
    check("t2_req1",  16'(imem_req), 16'd1);
    check("t2_addr1", imem_addr,     16'h0001);
    tick();
    check("t2_full_req", 16'(imem_req), 16'd0);
    check("t2_full_op",  op,            16'hA500);
    tick();
    check("t2_idle_req", 16'(imem_req), 16'd0);
    check("t2_idle_fpc", fetch_pc,      16'h0002);
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    check("t2_pop_op",    op,            16'hA501);
    check("t2_pop_op_pc", op_pc,         16'h0001);
    check("t2_pop_req",   16'(imem_req), 16'd0);
    tick();
    check("t2_re_req",  16'(imem_req), 16'd1);
    check("t2_re_addr", imem_addr,     16'h0002);
    tick();
    check("t2_one_req", 16'(imem_req), 16'd0);
    check("t2_head",    op,            16'hA501);
    tick();
    check("t2_one_req2", 16'(imem_req), 16'd0);

    // 3: ack after three wait cycles per request
    op_ready = 1'b1;
    imem_ack = 1'b0;
    do_reset();
    tick();
    for (int r = 0; r < 3; r++) begin
      for (int w = 0; w < 4; w++) begin
        imem_ack = (w == 3);
        check("t3_req",  16'(imem_req), 16'd1);
        check("t3_addr", imem_addr,     16'(r));
        if (w == 0 && r > 0) begin
          check("t3_valid", 16'(op_valid), 16'd1);
          check("t3_op",    op,            16'(r - 1) ^ 16'hA500);
        end else begin
          check("t3_empty_valid", 16'(op_valid), 16'd0);
          check("t3_empty_op",    op,            16'h0000);
        end
        tick();
      end
    end
    imem_ack = 1'b0;
    check("t3_last_op",    op,    16'hA502);
    check("t3_last_op_pc", op_pc, 16'h0002);

    // 4: redirect with a pending unacked read at addr 5
    imem_ack = 1'b1;
    do_reset();
    for (int k = 0; k < 6; k++) tick();
    check("t4_pre_addr", imem_addr, 16'h0005);
    imem_ack = 1'b0;
    redir_en = 1'b1;
    redir_pc = 16'h0040;
    tick();
    redir_en = 1'b0;
    check("t4_flush_valid", 16'(op_valid), 16'd0);
    check("t4_drop_req",    16'(imem_req), 16'd1);
    check("t4_drop_addr",   imem_addr,     16'h0005);
    check("t4_fpc",         fetch_pc,      16'h0040);
    tick();
    check("t4_hold_addr", imem_addr, 16'h0005);
    imem_ack = 1'b1;
    tick();
    check("t4_new_addr",  imem_addr,     16'h0040);
    check("t4_no_stale",  16'(op_valid), 16'd0);
    tick();
    check("t4_new_op",    op,    16'h0040 ^ 16'hA500);
    check("t4_new_op_pc", op_pc, 16'h0040);

    // 5: redirect coincident with ack and pop, then redirect twice through DROP
    do_reset();
    for (int k = 0; k < 3; k++) tick();
    check("t5_pre_valid", 16'(op_valid), 16'd1);
    redir_en = 1'b1;
    redir_pc = 16'h0080;
    tick();
    check("t5_flush_valid", 16'(op_valid), 16'd0);
    check("t5_req",         16'(imem_req), 16'd1);
    check("t5_addr",        imem_addr,     16'h0080);
    imem_ack = 1'b0;
    redir_pc = 16'h0090;
    tick();
    check("t5_drop_addr", imem_addr, 16'h0080);
    check("t5_fpc1",      fetch_pc,  16'h0090);
    redir_pc = 16'h00A0;
    tick();
    redir_en = 1'b0;
    check("t5_fpc2",       fetch_pc,  16'h00A0);
    check("t5_drop_addr2", imem_addr, 16'h0080);
    imem_ack = 1'b1;
    tick();
    check("t5_win_addr", imem_addr,     16'h00A0);
    check("t5_win_empty", 16'(op_valid), 16'd0);
    tick();
    check("t5_win_op_pc", op_pc, 16'h00A0);
    check("t5_win_op",    op,    16'h00A0 ^ 16'hA500);

    // 6: address wrap and async reset mid-request
    do_reset();
    tick();
    redir_en = 1'b1;
    redir_pc = 16'hFFFF;
    tick();
    redir_en = 1'b0;
    check("t6_addr_ffff", imem_addr, 16'hFFFF);
    tick();
    check("t6_addr_0",  imem_addr, 16'h0000);
    check("t6_op_ffff", op,        16'h5AFF);
    check("t6_pc_ffff", op_pc,     16'hFFFF);
    tick();
    check("t6_op_pc_0", op_pc,     16'h0000);
    check("t6_op_0",    op,        16'hA500);
    check("t6_addr_1",  imem_addr, 16'h0001);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_arst_req",   16'(imem_req), 16'd0);
    check("t6_arst_addr",  imem_addr,     16'h0000);
    check("t6_arst_valid", 16'(op_valid), 16'd0);
    check("t6_arst_op",    op,            16'h0000);
    check("t6_arst_op_pc", op_pc,         16'h0000);
    check("t6_arst_fpc",   fetch_pc,      16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
